ebi_bank_bridge: RTL
====================

# ebi_bank_bridge

Parametrised EBI multiplexed address/data slave bridge. It latches the word address on ALE and decodes a bank field. Each host read or write strobe becomes a single req/ack transaction on a generic internal bus, with a timeout. It sits between the top-level EBI pad ring and the register, BRAM and ADC-buffer banks. It replaces hard-wired per-bank decode with configurable widths, bank count, synchronisers and error reporting.

## Interface
- DATA_W, 16, EBI data width and internal bus data width
- BANK_W, 4, bank field width; bank = latched address bits [DATA_W-1 -: BANK_W]
- NUM_BANKS, 2, implemented banks (1..2^BANK_W); higher bank numbers are unmapped
- SYNC_STAGES, 2, synchroniser depth on ale_n/cs_n/re_n/we_n (>=2)
- TIMEOUT, 15, clk cycles to wait for bus_ack before abort (1..255)
- clk  in  1  system clock (100 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- ebi_ad_in  in  DATA_W  AD bus from pad D_IN
- ebi_ale_n  in  1  address latch enable, active low
- ebi_cs_n  in  1  chip select, active low
- ebi_re_n  in  1  read strobe, active low
- ebi_we_n  in  1  write strobe, active low
- ebi_ad_out  out  DATA_W  read data to pad D_OUT
- ebi_ad_oe  out  1  pad output enable
- bus_bank  out  BANK_W  decoded bank
- bus_addr  out  DATA_W-BANK_W+1  byte offset in bank: {low address bits, 1'b0}
- bus_req  out  1  transaction request, held until ack or abort
- bus_we  out  1  1 = write, 0 = read; valid while bus_req
- bus_wdata  out  DATA_W  write data; valid while bus_req
- bus_rdata  in  DATA_W  read data; sampled on the bus_ack cycle
- bus_ack  in  1  one-cycle completion from the target bank
- err_pulse  out  1  one-cycle pulse on timeout or unmapped-bank access
- timeout_cnt  out  8  saturating count of timeouts

## Operation
- Reset values: ebi_ad_out=0, ebi_ad_oe=0, bus_req=0, bus_we=0, bus_bank=0, bus_addr=0, bus_wdata=0, err_pulse=0, timeout_cnt=0. State resets to IDLE. Synchronisers reset to the inactive level (1).
- ebi_ad_in is delayed SYNC_STAGES registers so it stays aligned with the synchronised strobes.
- States: IDLE, ADDR, REQ, HOLD.
- IDLE: on a synced ale_n falling edge with cs_n low, latch bank and offset, then go to ADDR.
- ADDR:
  - A new ale_n falling edge relatches the address and stays in ADDR.
  - re_n low: read. If we_n is also low in the same cycle, the read wins.
  - we_n low: write; bus_wdata is taken from the aligned AD bus.
  - If the bank is mapped, assert bus_req and go to REQ.
  - If the bank is unmapped: a read loads ebi_ad_out=0, a write is dropped, err_pulse fires, and the state goes to HOLD.
- REQ:
  - Wait counter runs from 0.
  - On bus_ack: a read loads ebi_ad_out=bus_rdata; bus_req drops next cycle; go to HOLD.
  - If the counter reaches TIMEOUT with no ack: drop bus_req; a read loads all-ones; err_pulse fires; timeout_cnt increments, saturating at 255; go to HOLD.
  - ALE is ignored in REQ.
- HOLD: wait until both re_n and we_n are synced high, then go to IDLE. ebi_ad_out holds its value until the next read loads it.
- ebi_ad_oe = synced (!cs_n & !re_n), registered. It is independent of state, so the pad drives during the whole read strobe.
- cs_n synced high in any state: go to IDLE next cycle, with bus_req=0 and oe=0. An in-flight transaction is abandoned, and a late bus_ack is ignored.
- bus_ack outside REQ is ignored.

## Timing
- Pin-to-action latency is SYNC_STAGES+1 clk cycles: bus_req rises SYNC_STAGES+1 cycles after a strobe edge at the pin.
- Zero-wait target (ack in the first REQ cycle): read data is valid on ebi_ad_out SYNC_STAGES+3 cycles after the re_n falling edge.
- Host strobe width must be at least SYNC_STAGES+TIMEOUT+4 clk cycles for guaranteed read data.
- The ALE pulse must be at least 2 clk cycles wide, and the address must be stable for SYNC_STAGES+1 cycles after the ALE edge.
- bus_req/bus_we/bus_addr/bus_wdata are stable from req assertion to ack (or abort).
- Exactly one bus transaction per strobe assertion; no re-issue while in HOLD.

## Test plan
- Read bank 0 offset 0x0002, target acks in cycle 1 returning 0x5555 -> one bus_req with bus_we=0, bus_addr=0x0002; ebi_ad_out=0x5555 at SYNC_STAGES+3; oe high only while re_n low.
- Write 0xA5A5 to bank 1 offset 0x0010, ack after 3 cycles -> bus_wdata=0xA5A5, bus_we=1, one req lasting 3 cycles, no err_pulse.
- Read from bank 3 with NUM_BANKS=2 -> no bus_req; ebi_ad_out=0x0000; one err_pulse.
- Read with ack never returned, TIMEOUT=15 -> bus_req high exactly 15 cycles; ebi_ad_out=0xFFFF; timeout_cnt=1; repeat 300 times -> timeout_cnt=255.
- cs_n deasserted 2 cycles into REQ, then ack arrives -> bus_req drops; state returns to IDLE; ack ignored; ebi_ad_out unchanged.
- rst_n asserted mid-REQ -> all outputs return to their reset values immediately (asynchronously); the next ALE/read sequence completes normally after release.

Source files
------------

// File: rtl/ebi_bank_bridge_if.sv
// rtl/ebi_bank_bridge_if.sv - internal req/ack bank bus between the EBI bridge and its target banks
//
// Purpose: bundles the generic internal bus driven by ebi_bank_bridge.
// Ports (signals):
//   bus_bank  bridge->bank  decoded bank number
//   bus_addr  bridge->bank  byte offset inside the bank
//   bus_req   bridge->bank  request, held until ack or abort
//   bus_we    bridge->bank  1 = write, 0 = read
//   bus_wdata bridge->bank  write data
//   bus_rdata bank->bridge  read data, sampled with bus_ack
//   bus_ack   bank->bridge  one-cycle completion
// Modports: master (bridge side), slave (bank side).
interface ebi_bank_bridge_if #(
  parameter int DATA_W = 16,
  parameter int BANK_W = 4
);
  logic [BANK_W-1:0]      bus_bank;
  logic [DATA_W-BANK_W:0] bus_addr;
  logic                   bus_req;
  logic                   bus_we;
  logic [DATA_W-1:0]      bus_wdata;
  logic [DATA_W-1:0]      bus_rdata;
  logic                   bus_ack;

  modport master (
    output bus_bank, bus_addr, bus_req, bus_we, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_bank, bus_addr, bus_req, bus_we, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/ebi_bank_bridge.sv
// rtl/ebi_bank_bridge.sv - EBI multiplexed address/data slave bridge onto a req/ack bank bus
//
// Purpose: synchronises the EBI strobes, latches the word address on ALE,
// decodes the bank field and turns each read/write strobe into a single
// req/ack transaction with timeout and error reporting.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   ebi_ad_in        AD bus from the pad
//   ebi_ale_n/cs_n/re_n/we_n  EBI strobes, active low, asynchronous to clk
//   ebi_ad_out       read data to the pad
//   ebi_ad_oe        pad output enable
//   bus              internal bank bus (master side)
//   err_pulse        one-cycle pulse on timeout or unmapped-bank access
//   timeout_cnt      saturating timeout count
module ebi_bank_bridge #(
  parameter int DATA_W      = 16,
  parameter int BANK_W      = 4,
  parameter int NUM_BANKS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ebi_ad_in,
  input  logic              ebi_ale_n,
  input  logic              ebi_cs_n,
  input  logic              ebi_re_n,
  input  logic              ebi_we_n,
  output logic [DATA_W-1:0] ebi_ad_out,
  output logic              ebi_ad_oe,
  ebi_bank_bridge_if.master bus,
  output logic              err_pulse,
  output logic [7:0]        timeout_cnt
);

  localparam int                OFF_W   = DATA_W - BANK_W;
  localparam logic [BANK_W:0]   NB_LIM  = (BANK_W+1)'(NUM_BANKS);
  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, REQ, HOLD} state_t;

  // strobe synchronisers, idle level is high
  logic [SYNC_STAGES-1:0] ale_sr, cs_sr, re_sr, we_sr;
  logic [DATA_W-1:0]      ad_pipe [SYNC_STAGES];
  logic                   ale_prev;

  logic ale_s, cs_s, re_s, we_s, ale_fall;
  logic [DATA_W-1:0] ad_s;

  assign ale_s    = ale_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign re_s     = re_sr[SYNC_STAGES-1];
  assign we_s     = we_sr[SYNC_STAGES-1];
  assign ad_s     = ad_pipe[SYNC_STAGES-1];
  assign ale_fall = ale_prev & ~ale_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_sr   <= '1;
      cs_sr    <= '1;
      re_sr    <= '1;
      we_sr    <= '1;
      ale_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) ad_pipe[i] <= '0;
    end else begin
      ale_sr   <= {ale_sr[SYNC_STAGES-2:0], ebi_ale_n};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], ebi_cs_n};
      re_sr    <= {re_sr[SYNC_STAGES-2:0], ebi_re_n};
      we_sr    <= {we_sr[SYNC_STAGES-2:0], ebi_we_n};
      ale_prev <= ale_s;
      // AD travels the same depth as the strobes so both line up
      ad_pipe[0] <= ebi_ad_in;
      for (int i = 1; i < SYNC_STAGES; i++) ad_pipe[i] <= ad_pipe[i-1];
    end
  end

  state_t            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              req_d, we_d, err_d;
  logic [BANK_W-1:0] bank_d;
  logic [OFF_W:0]    addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [7:0]        tcnt_d;
  logic              rd, mapped;

  assign rd     = ~re_s;
  assign mapped = ({1'b0, bus.bus_bank} < NB_LIM);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = 1'b0;
    pdata_d = pdata_q;
    req_d   = bus.bus_req;
    we_d    = bus.bus_we;
    bank_d  = bus.bus_bank;
    addr_d  = bus.bus_addr;
    wdata_d = bus.bus_wdata;
    err_d   = 1'b0;
    tcnt_d  = timeout_cnt;

    if (cs_s) begin
      // deselect abandons anything in flight; a late ack lands outside REQ
      state_d = IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ale_fall) begin
            bank_d  = ad_s[DATA_W-1 -: BANK_W];
            addr_d  = {ad_s[OFF_W-1:0], 1'b0};
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (ale_fall) begin
            bank_d = ad_s[DATA_W-1 -: BANK_W];
            addr_d = {ad_s[OFF_W-1:0], 1'b0};
          end else if (!re_s || !we_s) begin
            if (mapped) begin
              req_d   = 1'b1;
              we_d    = ~rd;  // read wins when both strobes are low
              wait_d  = '0;
              if (!rd) wdata_d = ad_s;
              state_d = REQ;
            end else begin
              err_d = 1'b1;
              if (rd) begin
                pend_d  = 1'b1;
                pdata_d = '0;
              end
              state_d = HOLD;
            end
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            req_d = 1'b0;
            if (!bus.bus_we) begin
              pend_d  = 1'b1;
              pdata_d = bus.bus_rdata;
            end
            state_d = HOLD;
          end else if (wait_q == TO_LAST) begin
            req_d = 1'b0;
            err_d = 1'b1;
            if (!bus.bus_we) begin
              pend_d  = 1'b1;
              pdata_d = '1;
            end
            if (timeout_cnt != 8'hFF) tcnt_d = timeout_cnt + 8'd1;
            state_d = HOLD;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        HOLD: begin
          if (re_s && we_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      pend_q        <= 1'b0;
      pdata_q       <= '0;
      ebi_ad_out    <= '0;
      ebi_ad_oe     <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_bank  <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      err_pulse     <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      pend_q        <= pend_d;
      pdata_q       <= pdata_d;
      // captured read result reaches the pad one cycle after it is taken
      if (pend_q) ebi_ad_out <= pdata_q;
      ebi_ad_oe     <= ~cs_s & ~re_s;
      bus.bus_req   <= req_d;
      bus.bus_we    <= we_d;
      bus.bus_bank  <= bank_d;
      bus.bus_addr  <= addr_d;
      bus.bus_wdata <= wdata_d;
      err_pulse     <= err_d;
      timeout_cnt   <= tcnt_d;
    end
  end

endmodule
